// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and us-to-cycle helpers for the servo driver
package servo_pkg;

  function automatic int us_to_cyc(input int clk_hz, input int us);
    return (clk_hz / 1000000) * us;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int mid_code(input int data_w);
    return 1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/servo_driver_multi_if.sv
// rtl/servo_driver_multi_if.sv - position-write handshake bundle
interface servo_driver_multi_if #(
  parameter int CH_W   = 2,
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_ch, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_data, output wr_ready);
endinterface

// File: rtl/servo_pwm_channel.sv
// rtl/servo_pwm_channel.sv - one servo channel: target/active codes and pulse compare
// SERVO_SLEW_LIMIT_EN: limits the per-frame change of the active code to SLEW_STEP.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 20,
  parameter int MIN_CYC  = 12000,
  parameter int STEP_CYC = 188
`ifdef SERVO_SLEW_LIMIT_EN
  , parameter int SLEW_STEP = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              shadow_load,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  cnt,
  output logic              pulse
);

  localparam logic [DATA_W-1:0] MID = DATA_W'(mid_code(DATA_W));

  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] active;
  logic [DATA_W-1:0] load_val;
  logic [CNT_W-1:0]  width;

  // The widest legal pulse is below the frame length, so CNT_W bits never overflow.
  always_comb begin
    width = CNT_W'(MIN_CYC) + CNT_W'(active) * CNT_W'(STEP_CYC);
  end

`ifdef SERVO_SLEW_LIMIT_EN
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] step;

  always_comb begin
    diff     = (target > active) ? (target - active) : (active - target);
    step     = (int'(diff) > SLEW_STEP) ? DATA_W'(SLEW_STEP) : diff;
    load_val = (target > active) ? (active + step) : (active - step);
  end
`else
  always_comb begin
    load_val = target;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target <= MID;
      active <= MID;
      pulse  <= 1'b0;
    end else begin
      if (wr_en) begin
        target <= wr_data;
      end
      // Stopped outputs track the target immediately so a restart needs no ramp.
      if (!enable) begin
        active <= target;
      end else if (shadow_load) begin
        active <= load_val;
      end
      pulse <= enable && (cnt < width);
    end
  end

endmodule

// File: rtl/servo_driver_multi.sv
// rtl/servo_driver_multi.sv - multi-channel servo pulse generator with frame counter
// SERVO_SLEW_LIMIT_EN: enables per-frame slew limiting in every channel.
module servo_driver_multi
  import servo_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int CLK_HZ    = 24000000,
  parameter int PERIOD_US = 30000,
  parameter int MIN_US    = 500,
  parameter int MAX_US    = 2500,
  parameter int SLEW_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  servo_driver_multi_if.slave wr,
  output logic [NUM_CH-1:0] servo_pulse,
  output logic              frame_start
);

  localparam int CH_W       = ch_w(NUM_CH);
  localparam int PERIOD_CYC = us_to_cyc(CLK_HZ, PERIOD_US);
  localparam int MIN_CYC    = us_to_cyc(CLK_HZ, MIN_US);
  localparam int STEP_CYC   = us_to_cyc(CLK_HZ, MAX_US - MIN_US) / ((1 << DATA_W) - 1);
  localparam int CNT_W      = $clog2(PERIOD_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("servo_driver_multi: NUM_CH must be 1..16");
  end
  if (MIN_CYC + ((1 << DATA_W) - 1) * STEP_CYC >= PERIOD_CYC) begin : g_bad_period
    $error("servo_driver_multi: full-scale pulse does not fit in the frame");
  end
  // A negative step has no meaning in any build.
  if (SLEW_STEP < 0) begin : g_bad_slew
    $error("servo_driver_multi: SLEW_STEP must not be negative");
  end

  logic [CNT_W-1:0] cnt;
  logic             shadow_load;
  logic             wr_ready_int;
  logic             wr_fire;

  always_comb begin
    shadow_load  = enable && (cnt == LAST);
    wr_ready_int = rst_n && !shadow_load;
    wr_fire      = wr.wr_valid && wr_ready_int;
    frame_start  = rst_n && enable && (cnt == '0);
  end

  assign wr.wr_ready = wr_ready_int;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_channel #(
      .DATA_W   (DATA_W),
      .CNT_W    (CNT_W),
      .MIN_CYC  (MIN_CYC),
      .STEP_CYC (STEP_CYC)
`ifdef SERVO_SLEW_LIMIT_EN
      , .SLEW_STEP(SLEW_STEP)
`endif
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .shadow_load (shadow_load),
      .wr_en       (wr_fire && (wr.wr_ch == CH_W'(i))),
      .wr_data     (wr.wr_data),
      .cnt         (cnt),
      .pulse       (servo_pulse[i])
    );
  end

endmodule

// File: tb/tb_servo_driver_multi.sv
// tb/tb_servo_driver_multi.sv - self-checking bench with a cycle model and measured widths
module tb_servo_driver_multi;
  import servo_pkg::*;

  localparam int NUM_CH    = 3;
  localparam int DATA_W    = 4;
  localparam int CLK_HZ    = 2000000;
  localparam int PERIOD_US = 60;
  localparam int MIN_US    = 5;
  localparam int MAX_US    = 50;
  localparam int SLEW_STEP = 2;
  localparam int CH_W      = 2;

  // Hand-derived: 2 cycles/us -> period 120, min 10, step (2*45)/15 = 6, mid code 8.
  localparam int PERIOD = 120;
  localparam int LAST   = 119;
  localparam int MINC   = 10;
  localparam int STEPC  = 6;
  localparam int MID    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [NUM_CH-1:0] servo_pulse;
  logic              frame_start;

  servo_driver_multi_if #(.CH_W(CH_W), .DATA_W(DATA_W)) wr ();

  servo_driver_multi #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US),
    .MIN_US(MIN_US), .MAX_US(MAX_US), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr),
    .servo_pulse(servo_pulse), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: integer codes per channel, frame position, expected pulses.
  int                m_cnt = 0;
  int                m_tgt[NUM_CH];
  int                m_act[NUM_CH];
  logic [NUM_CH-1:0] m_pulse = '0;
  bit                m_live = 1'b0;
  bit                m_rdy;

  function automatic int width_of(input int code);
    return MINC + code * STEPC;
  endfunction

  function automatic int toward(input int a, input int t);
`ifdef SERVO_SLEW_LIMIT_EN
    if (t > a) return a + ((t - a) < SLEW_STEP ? (t - a) : SLEW_STEP);
    else       return a - ((a - t) < SLEW_STEP ? (a - t) : SLEW_STEP);
`else
    return t + 0 * a;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live  = 1'b1;
      m_cnt   = 0;
      m_pulse = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_tgt[i] = MID;
        m_act[i] = MID;
      end
    end else if (m_live) begin
      m_rdy = !(enable && m_cnt == LAST);
      for (int i = 0; i < NUM_CH; i++) begin
        m_pulse[i] = enable && (m_cnt < width_of(m_act[i]));
        if (!enable)            m_act[i] = m_tgt[i];
        else if (m_cnt == LAST) m_act[i] = toward(m_act[i], m_tgt[i]);
      end
      if (wr.wr_valid && m_rdy && int'(wr.wr_ch) < NUM_CH)
        m_tgt[wr.wr_ch] = int'(wr.wr_data);
      m_cnt = (!enable || m_cnt == LAST) ? 0 : m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("pulse", 32'(servo_pulse), 32'(m_pulse));
      chk("frame_start", 32'(frame_start), 32'(rst_n && enable && m_cnt == 0));
      chk("wr_ready", 32'(wr.wr_ready), 32'(rst_n && !(enable && m_cnt == LAST)));
    end
  end

  // Measured high time per channel over the previous frame, and frame period.
  int acc[NUM_CH];
  int last_w[NUM_CH];
  int fs_gap = 0;
  int last_period = 0;

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      acc[i] = 0;
      last_w[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (frame_start === 1'b1) begin
      for (int i = 0; i < NUM_CH; i++) begin
        last_w[i] = acc[i];
        acc[i] = 0;
      end
      last_period = fs_gap;
      fs_gap = 0;
    end
    fs_gap++;
    for (int i = 0; i < NUM_CH; i++)
      if (servo_pulse[i] === 1'b1) acc[i]++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt(input int c);
    int k;
    for (k = 0; k < 300; k++) begin
      if (m_cnt == c) break;
      tick(1);
    end
    if (k >= 300) chk("wait_cnt_timeout", 0, 1);
  endtask

  task automatic wait_frames(input int n);
    int k;
    repeat (n) begin
      k = 0;
      @(negedge clk);
      while (frame_start !== 1'b1 && k < 300) begin
        @(negedge clk);
        k++;
      end
      if (k >= 300) chk("frame_timeout", 0, 1);
      #1;
    end
  endtask

  task automatic do_write(input int ch, input int data, output int stalls);
    logic r;
    wr.wr_valid = 1'b1;
    wr.wr_ch    = CH_W'(ch);
    wr.wr_data  = DATA_W'(data);
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r = wr.wr_ready;
      @(posedge clk);
      #1;
      if (r === 1'b1) break;
      stalls++;
    end
    wr.wr_valid = 1'b0;
    if (stalls >= 20) chk("write_timeout", 0, 1);
  endtask

  task automatic chk_w(input int i, input int exp);
    chk($sformatf("width_ch%0d", i), 32'(last_w[i]), 32'(exp));
  endtask

  int s;

  initial begin
    wr.wr_valid = 1'b0;
    wr.wr_ch    = '0;
    wr.wr_data  = '0;
    tick(3);
    chk("reset_ready", 32'(wr.wr_ready), 0);
    chk("reset_pulse", 32'(servo_pulse), 0);
    chk("reset_frame_start", 32'(frame_start), 0);

    rst_n  = 1'b1;
    enable = 1'b1;
    wait_frames(3);
    for (int i = 0; i < NUM_CH; i++) chk_w(i, 58);
    chk("frame_period", 32'(last_period), PERIOD);

    // Mid-frame writes take effect only from the next frame.
    wait_cnt(30);
    do_write(1, 0, s);
    do_write(2, 15, s);
    wait_frames(1);
    chk_w(1, 58);
    chk_w(2, 58);
    wait_frames(1);
`ifdef SERVO_SLEW_LIMIT_EN
    chk_w(1, 46);
    chk_w(2, 70);
`else
    chk_w(1, 10);
    chk_w(2, 100);
`endif
    chk_w(0, 58);
    wait_frames(4);
    chk_w(1, 10);
    chk_w(2, 100);

    // Write held across the shadow-load cycle stalls exactly once.
    wait_cnt(LAST);
    do_write(0, 3, s);
    chk("shadow_stalls", 32'(s), 1);
    wait_frames(2);
`ifdef SERVO_SLEW_LIMIT_EN
    chk_w(0, 46);
`else
    chk_w(0, 28);
`endif

    // Disable mid-pulse, write while stopped, re-enable.
    wait_cnt(20);
    enable = 1'b0;
    tick(1);
    chk("disable_pulse", 32'(servo_pulse), 0);
    do_write(0, 10, s);
    tick(5);
    enable = 1'b1;
    wait_frames(2);
    chk_w(0, 70);

    // Out-of-range channel is accepted and dropped.
    do_write(3, 1, s);
    chk("discard_stalls", 32'(s), 0);
    wait_frames(2);
    chk_w(0, 70);
    chk_w(1, 10);
    chk_w(2, 100);

    // Reset mid-pulse truncates and restores the mid code.
    wait_cnt(30);
    rst_n = 1'b0;
    tick(1);
    chk("reset_mid_pulse", 32'(servo_pulse), 0);
    chk("reset_mid_ready", 32'(wr.wr_ready), 0);
    tick(2);
    rst_n = 1'b1;
    wait_frames(2);
    for (int i = 0; i < NUM_CH; i++) chk_w(i, 58);

    // Random traffic against the cycle model.
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      rst_n       = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      wr.wr_valid = ($urandom_range(0, 2) == 0);
      wr.wr_ch    = CH_W'($urandom_range(0, 3));
      wr.wr_data  = DATA_W'($urandom_range(0, 15));
    end
    wr.wr_valid = 1'b0;
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
